// File: rtl/weight_pkg.sv
// Shared defaults and FSM encoding for the weight fetch controller.
package weight_pkg;

  localparam int unsigned DEPTH_DEF  = 28;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry shift FIFO; the head always sits in entry 0 and empty slots read as zero.
module weight_skid_fifo
  import weight_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);

  logic [W-1:0] mem0_q;
  logic [W-1:0] mem1_q;
  logic [1:0]   occ_q;
  logic         do_push;
  logic         do_pop;

  // A pop on an empty buffer or a push into a full one without a pop is ignored.
  assign do_pop  = pop && (occ_q != 2'd0);
  assign do_push = push && ((occ_q != 2'd2) || do_pop);

  // Storage and occupancy update; simultaneous push and pop keeps occ unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) mem0_q <= din;
          else               mem1_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          mem0_q <= mem1_q;
          mem1_q <= '0;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            mem0_q <= mem1_q;
            mem1_q <= din;
          end else begin
            mem0_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = mem0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams DEPTH weight words from a negedge-read BRAM to a ready/valid consumer.
module weight_fetch_ctrl
  import weight_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  issued_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic              busy_q;
  logic              done_q;
  logic              issue;
  logic              pop;
  logic              is_last;
  logic [1:0]        occ;
  logic [DATA_W:0]   head;

  assign pop     = W_VALID & W_READY;
  assign is_last = (issued_q == CNT_W'(DEPTH - 1));

  // State register; reset wins over any START in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and read issue; issue depends on this cycle's pop, so it is combinational.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_RUN;
      end
      ST_RUN: begin
        issue = (issued_q < CNT_W'(DEPTH)) &&
                ((3'(occ) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
        if (pop && W_LAST) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Issue counter, held read address, in-flight flag and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      issued_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FINISH);
      if (state_q == ST_IDLE && START) issued_q <= '0;
      else if (issue)                  issued_q <= issued_q + CNT_W'(1);
      if (issue) addr_q <= issued_q[ADDR_W-1:0];
    end
  end

  // BRAM data lands at the edge after the issue cycle, tagged with its last flag.
  weight_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (issue),
    .pop  (pop),
    .din  ({is_last, BRAM_DO}),
    .dout (head),
    .occ  (occ)
  );

  assign BRAM_EN   = issue;
  assign BRAM_ADDR = issue ? issued_q[ADDR_W-1:0] : addr_q;
  assign BRAM_WE   = 1'b0;
  assign W_VALID   = (occ != 2'd0);
  assign W_DATA    = head[DATA_W-1:0];
  assign W_LAST    = head[DATA_W];
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a negedge-read BRAM model.
module tb_weight_fetch_ctrl;

  localparam int DEPTH = 28;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [4:0]  BRAM_ADDR;
  logic        BRAM_EN;
  logic        BRAM_WE;
  logic [15:0] BRAM_DO;
  logic [15:0] W_DATA;
  logic        W_VALID;
  logic        W_READY;
  logic        W_LAST;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;
  int gcyc  = 0;
  int exp_addr;
  int n_acc;
  int last_acc;

  logic [15:0] mem [0:31];

  typedef struct {
    logic        start;
    logic        rdy;
    logic        en;
    logic [4:0]  addr;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [33];

  weight_fetch_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_EN   (BRAM_EN),
    .BRAM_WE   (BRAM_WE),
    .BRAM_DO   (BRAM_DO),
    .W_DATA    (W_DATA),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .W_LAST    (W_LAST),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // BRAM reads on the falling edge so data is ready at the next rising edge.
  initial BRAM_DO = 16'h0000;
  always @(negedge CLK) begin
    if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, gcyc, act, exp);
    end
  endtask

  // Drive inputs just after the rising edge, then let outputs settle before checks.
  task automatic next_cycle(input logic st, input logic rdy, input logic rst);
    @(posedge CLK);
    #1;
    START   = st;
    W_READY = rdy;
    RST     = rst;
    #2;
    gcyc++;
  endtask

  // Per-cycle scoreboard: issue order, head word, last flag and issue lead.
  task automatic sb_cycle();
    check("we_zero", 32'(BRAM_WE), 32'd0);
    if (BRAM_EN) begin
      check("issue_addr", 32'(BRAM_ADDR), 32'(exp_addr));
      check("issue_in_range", 32'(exp_addr < DEPTH), 32'd1);
      exp_addr++;
    end
    if (W_VALID) begin
      check("w_data", 32'(W_DATA), 32'(16'h0100 + n_acc));
      check("w_last", 32'(W_LAST), 32'(n_acc == DEPTH - 1));
      if (W_READY) begin
        n_acc++;
        last_acc = gcyc;
      end
    end else begin
      check("w_last_idle", 32'(W_LAST), 32'd0);
    end
    check("ahead_le2", 32'((exp_addr - n_acc) <= 2), 32'd1);
  endtask

  // mode 0: full rate, 1: stall cycles 3..10, 2: random ready, 3: extra START at cycle 10.
  task automatic run_transfer(input int mode);
    bit   done_seen;
    logic st;
    logic rdy;
    exp_addr  = 0;
    n_acc     = 0;
    last_acc  = -10;
    done_seen = 0;
    next_cycle(1'b1, (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    check("busy_c0", 32'(BUSY), 32'd0);
    check("done_c0", 32'(DONE), 32'd0);
    sb_cycle();
    for (int c = 1; c <= 400 && !done_seen; c++) begin
      st  = (mode == 3) && (c == 10);
      rdy = (mode == 1) ? !(c >= 3 && c <= 10) :
            (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      next_cycle(st, rdy, 1'b0);
      sb_cycle();
      check("busy_run", 32'(BUSY), 32'd1);
      if (DONE) begin
        done_seen = 1;
        check("done_count", 32'(n_acc), 32'(DEPTH));
        check("done_issued", 32'(exp_addr), 32'(DEPTH));
        check("done_after_last", 32'(gcyc), 32'(last_acc + 1));
        if (mode == 0 || mode == 3) check("done_cycle", 32'(c), 32'd30);
      end
      if (mode == 1 && c >= 3 && c <= 10) begin
        check("bp_valid", 32'(W_VALID), 32'd1);
        check("bp_hold", 32'(W_DATA), 32'h0101);
      end
      if ((mode == 0 || mode == 3) && c == 29) check("last_cycle", 32'(W_LAST), 32'd1);
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0;
    RST     = 1'b1;
    START   = 1'b0;
    W_READY = 1'b1;
    for (int k = 0; k < 32; k++) mem[k] = 16'h0100 + 16'(k);

    // Full-rate expectations, one record per cycle starting at the START cycle.
    for (int c = 0; c < 33; c++) begin
      tbl[c].start = (c == 0);
      tbl[c].rdy   = 1'b1;
      tbl[c].en    = (c >= 1 && c <= 28);
      tbl[c].addr  = (c == 0) ? 5'd0 : (c <= 28) ? 5'(c - 1) : 5'd27;
      tbl[c].valid = (c >= 2 && c <= 29);
      tbl[c].data  = 16'h0100 + 16'(c - 2);
      tbl[c].last  = (c == 29);
      tbl[c].busy  = (c >= 1 && c <= 30);
      tbl[c].done  = (c == 30);
    end

    // Reset state.
    next_cycle(1'b0, 1'b1, 1'b1);
    check("rst_en", 32'(BRAM_EN), 32'd0);
    check("rst_addr", 32'(BRAM_ADDR), 32'd0);
    check("rst_valid", 32'(W_VALID), 32'd0);
    check("rst_last", 32'(W_LAST), 32'd0);
    check("rst_data", 32'(W_DATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_we", 32'(BRAM_WE), 32'd0);

    // Table-driven full-rate transfer.
    for (int c = 0; c < 33; c++) begin
      next_cycle(tbl[c].start, tbl[c].rdy, 1'b0);
      check("tbl_en", 32'(BRAM_EN), 32'(tbl[c].en));
      check("tbl_addr", 32'(BRAM_ADDR), 32'(tbl[c].addr));
      check("tbl_valid", 32'(W_VALID), 32'(tbl[c].valid));
      if (tbl[c].valid) check("tbl_data", 32'(W_DATA), 32'(tbl[c].data));
      check("tbl_last", 32'(W_LAST), 32'(tbl[c].last));
      check("tbl_busy", 32'(BUSY), 32'(tbl[c].busy));
      check("tbl_done", 32'(DONE), 32'(tbl[c].done));
      check("tbl_we", 32'(BRAM_WE), 32'd0);
    end

    // Scoreboarded full rate, backpressure, START in RUN, then back-to-back restart.
    run_transfer(0);
    run_transfer(1);
    run_transfer(3);
    run_transfer(0);

    // Random ready for about 1000 cycles of back-to-back transfers.
    t0 = gcyc;
    while (gcyc - t0 < 1000) run_transfer(2);

    // Reset in cycle 15 of a transfer.
    exp_addr = 0;
    n_acc    = 0;
    next_cycle(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      next_cycle(1'b0, 1'b1, 1'b0);
      sb_cycle();
    end
    next_cycle(1'b0, 1'b1, 1'b1);
    next_cycle(1'b0, 1'b1, 1'b0);
    check("mrst_en", 32'(BRAM_EN), 32'd0);
    check("mrst_addr", 32'(BRAM_ADDR), 32'd0);
    check("mrst_valid", 32'(W_VALID), 32'd0);
    check("mrst_last", 32'(W_LAST), 32'd0);
    check("mrst_data", 32'(W_DATA), 32'd0);
    check("mrst_busy", 32'(BUSY), 32'd0);
    check("mrst_done", 32'(DONE), 32'd0);
    for (int c = 0; c < 5; c++) begin
      next_cycle(1'b0, 1'b1, 1'b0);
      check("mrst_quiet_valid", 32'(W_VALID), 32'd0);
      check("mrst_quiet_busy", 32'(BUSY), 32'd0);
    end

    // Reset and START together: reset wins.
    next_cycle(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      next_cycle(1'b0, 1'b1, 1'b0);
      check("prio_busy", 32'(BUSY), 32'd0);
      check("prio_en", 32'(BRAM_EN), 32'd0);
      check("prio_valid", 32'(W_VALID), 32'd0);
    end

    // Clean transfer after reset.
    run_transfer(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 28: number of weight words streamed per START.
REQ-002 SHALL provide parameter ADDR_W, default 5: BRAM address width.
REQ-003 SHALL provide parameter DATA_W, default 16: weight word width.
REQ-004 CLK  input  1  single clock; all logic on posedge CLK.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 START  input  1  one-cycle request to stream words 0..DEPTH-1.
REQ-007 BRAM_ADDR  output  ADDR_W  read address to weight BRAM.
REQ-008 BRAM_EN  output  1  BRAM enable, high only in a read-issue cycle.
REQ-009 BRAM_WE  output  1  BRAM write enable, constant 0.
REQ-010 BRAM_DO  input  DATA_W  BRAM read data; valid at the posedge after the issue cycle, because the BRAM samples on negedge.
REQ-011 W_DATA  output  DATA_W  weight word to downstream MAC.
REQ-012 W_VALID  output  1  W_DATA valid.
REQ-013 W_READY  input  1  downstream accepts W_DATA.
REQ-014 W_LAST  output  1  high with the word from address DEPTH-1.
REQ-015 BUSY  output  1  transfer in progress.
REQ-016 DONE  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 SHALL implement states IDLE, RUN and FINISH.
- IDLE->RUN when START=1.
- RUN->FINISH when the word with W_LAST is accepted (W_VALID&W_READY).
- FINISH->IDLE unconditionally after one cycle.
REQ-018 SHALL ignore START in RUN and FINISH.
REQ-019 SHALL assert BUSY in RUN and FINISH, and deassert it in IDLE.
REQ-020 SHALL assert DONE only in FINISH.
REQ-021 SHALL issue reads in ascending order 0..DEPTH-1, exactly once each; BRAM_ADDR holds its last value when BRAM_EN=0.
REQ-022 SHALL issue a read in RUN only when issued<DEPTH and occ+inflight-pop<2.
- occ = buffer occupancy, 0..2.
- inflight = 1 if a read was issued in the previous cycle.
- pop = W_VALID&W_READY.
REQ-023 SHALL capture BRAM_DO into a 2-entry FIFO at the posedge following each issue cycle.
REQ-024 SHALL drive W_VALID = (occ>0), with W_DATA and W_LAST taken from the FIFO head.
REQ-025 SHALL hold W_DATA and W_LAST stable while W_VALID=1 and W_READY=0.
REQ-026 SHALL never overflow the FIFO or drop a word under any W_READY pattern.
REQ-027 SHALL handle simultaneous capture and pop in one cycle, leaving occ unchanged.
REQ-028 SHALL achieve the following timing with W_READY held at 1 and START sampled in cycle 0:
- first issue in cycle 1;
- W_VALID with word 0 in cycle 2;
- one word per cycle;
- W_LAST in cycle DEPTH+1;
- DONE in cycle DEPTH+2.
REQ-029 SHALL use a 0..DEPTH counter (width ADDR_W+1) for the issued count, so that DEPTH=2^ADDR_W also works.
REQ-030 SHALL allow a START in the cycle after FINISH, which begins a new transfer from address 0.

Reset
REQ-031 SHALL, with RST=1 at a posedge, force on the same edge:
- state IDLE;
- BRAM_EN=0, BRAM_ADDR=0;
- W_VALID=0, W_LAST=0, W_DATA=0;
- BUSY=0, DONE=0;
- occ=0, inflight=0, issued count=0.
REQ-032 SHALL, when reset occurs mid-transfer, discard in-flight and buffered words; no W_VALID appears until the next START.
REQ-033 SHALL give RST priority over START in the same cycle.

Structure
REQ-034 SHALL take DEPTH, ADDR_W and DATA_W defaults and the state encoding from the shared package weight_pkg.
REQ-035 SHALL implement the 2-entry buffer as sub-module weight_skid_fifo (push, pop, din, dout, occ), and keep the FSM and issue logic in weight_fetch_ctrl.

Verification
REQ-036 Bench SHALL model the BRAM (negedge read, DEPTH=28) with word k = 16'h0100+k.
REQ-037 Full rate: W_READY=1, START in cycle 0 -> words 0x0100..0x011B in cycles 2..29 in order, W_LAST only in cycle 29, DONE in cycle 30, BUSY high in cycles 1..30.
REQ-038 Backpressure: W_READY=0 during cycles 3..10 -> W_DATA held at 0x0101; never more than 2 issues ahead of the last accepted word; all 28 words delivered once, in order.
REQ-039 Random W_READY, 50% duty, 1000 cycles -> exactly 28 accepted words per START, no duplicates or gaps, BRAM_WE always 0.
REQ-040 START in RUN (cycle 10) -> ignored, single sequence of 28 words; START one cycle after DONE -> second sequence starting at address 0.
REQ-041 RST in cycle 15 of a transfer -> all outputs 0 in cycle 16, no W_VALID until a new START, then a clean sequence from 0x0100.
